// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_FULL
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Clears the byte-offset bits so every fetch address is word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundles the IMEM request/response, redirect and downstream handshake
// signals of the fetch stage. The signal names are written from the fetch
// stage's point of view; "master" is the fetch stage, "slave" is everything around it.
interface instr_fetch_if;

   logic        o_imemReqValid;
   logic        i_imemReqReady;
   logic [31:0] o_imemAddr;
   logic        i_imemRspValid;
   logic [31:0] i_imemRspData;
   logic        i_redirectValid;
   logic [31:0] i_redirectPC;
   logic        o_instrValid;
   logic        i_instrReady;
   logic [31:0] o_PC;
   logic [31:0] o_instr;

   modport master (
      output o_imemReqValid, o_imemAddr, o_instrValid, o_PC, o_instr,
      input  i_imemReqReady, i_imemRspValid, i_imemRspData,
             i_redirectValid, i_redirectPC, i_instrReady
   );

   modport slave (
      input  o_imemReqValid, o_imemAddr, o_instrValid, o_PC, o_instr,
      output i_imemReqReady, i_imemRspValid, i_imemRspData,
             i_redirectValid, i_redirectPC, i_instrReady
   );

endinterface

// File: rtl/instr_fetch_sync_fifo.sv
// Small synchronous FIFO with flush. A push is accepted on a full FIFO
// when a pop happens in the same cycle, since the pop frees the slot.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         popData,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rdPtr;
   logic [AW-1:0]    wrPtr;
   logic             doPush;
   logic             doPop;

   assign doPop   = pop && !empty;
   assign doPush  = push && (!full || doPop);
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign popData = mem[rdPtr];

   // Pointer and occupancy bookkeeping; a flush empties the FIFO in one cycle
   // without touching the storage itself.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
      end
   end

   // Storage is write-only on push; stale contents are never visible because
   // the consumer masks the head with the empty flag.
   always_ff @(posedge clock) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/instr_fetch.sv
// In-order instruction fetch stage: owns the fetch PC, issues word reads to
// IMEM, tags each returned word with its PC and hands {PC, instr} downstream.
// A redirect restarts fetch and discards every response still in flight.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          FIFO_DEPTH = 2
) (
   input logic           i_clock,
   input logic           i_reset,
   instr_fetch_if.master bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t  state;
   logic [31:0]   fetchPC;
   logic [CW-1:0] inFlight;
   logic [CW-1:0] dropCount;
   logic [CW-1:0] bufCount;
   logic [CW-1:0] tagCount;
   logic [CW:0]   occupancy;
   logic [CW:0]   credit;
   logic          creditAvail;
   logic          redirect;
   logic          reqFire;
   logic          rspForDrop;
   logic          rspForTag;
   logic          rspAccepted;
   logic          instrPop;
   logic          bufEmpty;
   logic          bufFull;
   logic          tagEmpty;
   logic          tagFull;
   logic [31:0]   tagHead;
   fetch_entry_t  bufHead;
   fetch_entry_t  bufPushEntry;

   assign redirect = bus.i_redirectValid;

   // Dropped requests still hold a slot until their response comes back,
   // and a pop this cycle already frees a slot for a new request.
   assign instrPop    = !bufEmpty && bus.i_instrReady && !redirect;
   assign occupancy   = {1'b0, inFlight} + {1'b0, dropCount} + {1'b0, bufCount};
   assign credit      = (CW+1)'(FIFO_DEPTH) - occupancy + (CW+1)'(instrPop);
   assign creditAvail = (credit != '0);

   assign bus.o_imemReqValid = (state == S_FETCH) && creditAvail && !redirect;
   assign bus.o_imemAddr     = fetchPC;
   assign reqFire            = bus.o_imemReqValid && bus.i_imemReqReady;

   // A response either pays off a pending drop or belongs to the oldest tag.
   assign rspForDrop  = bus.i_imemRspValid && (dropCount != '0);
   assign rspForTag   = bus.i_imemRspValid && (dropCount == '0) && (inFlight != '0);
   assign rspAccepted = rspForTag && !redirect;

   assign bufPushEntry     = '{pc: tagHead, instr: bus.i_imemRspData};
   assign bus.o_instrValid = !bufEmpty;
   assign bus.o_PC         = bufEmpty ? 32'h0000_0000 : bufHead.pc;
   assign bus.o_instr      = bufEmpty ? NOP_INSTR : bufHead.instr;

   // Sequencer: one idle cycle after reset, then fetch until credit runs out.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:  state <= S_FETCH;
            S_FETCH: if (!creditAvail) state <= S_FULL;
            S_FULL:  if (creditAvail)  state <= S_FETCH;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Fetch PC advances on every accepted request and jumps on a redirect.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         fetchPC <= RESET_PC;
      end else if (redirect) begin
         fetchPC <= word_align(bus.i_redirectPC);
      end else if (reqFire) begin
         fetchPC <= fetchPC + 32'd4;
      end
   end

   // On a redirect every live request becomes one to drop, except a response
   // arriving that same cycle, which is consumed and discarded right away.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         inFlight  <= '0;
         dropCount <= '0;
      end else if (redirect) begin
         inFlight  <= '0;
         dropCount <= dropCount + inFlight - CW'(rspForDrop || rspForTag);
      end else begin
         inFlight  <= inFlight + CW'(reqFire) - CW'(rspAccepted);
         dropCount <= dropCount - CW'(rspForDrop);
      end
   end

   sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tagQueue (
      .clock    (i_clock),
      .reset    (i_reset),
      .push     (reqFire),
      .pushData (fetchPC),
      .pop      (rspAccepted),
      .popData  (tagHead),
      .flush    (redirect),
      .full     (tagFull),
      .empty    (tagEmpty),
      .count    (tagCount)
   );

   sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_instrBuf (
      .clock    (i_clock),
      .reset    (i_reset),
      .push     (rspAccepted),
      .pushData (bufPushEntry),
      .pop      (instrPop),
      .popData  (bufHead),
      .flush    (redirect),
      .full     (bufFull),
      .empty    (bufEmpty),
      .count    (bufCount)
   );

   // Internal consistency: the tag queue mirrors the live request count and
   // neither queue is ever over- or under-run.
   a_noOrphanRsp: assert property (@(posedge i_clock) disable iff (i_reset)
      !(bus.i_imemRspValid && inFlight == '0 && dropCount == '0));
   a_tagMatchesInFlight: assert property (@(posedge i_clock) disable iff (i_reset)
      tagCount == inFlight);
   a_tagNoOverflow: assert property (@(posedge i_clock) disable iff (i_reset)
      !(reqFire && tagFull));
   a_tagNoUnderflow: assert property (@(posedge i_clock) disable iff (i_reset)
      !(rspAccepted && tagEmpty));
   a_bufNoOverflow: assert property (@(posedge i_clock) disable iff (i_reset)
      !(rspAccepted && bufFull && !instrPop));

endmodule
